// File: rtl/lenet_fxp_pkg.sv
// Shared Q6.10 fixed-point definitions for the LeNet datapath blocks.
package lenet_fxp_pkg;

  localparam int FXP_DATA_WIDTH = 16;
  localparam int FXP_INTEGER    = 6;
  localparam int FXP_FRACTION   = 10;

  typedef logic signed [FXP_DATA_WIDTH-1:0] fxp_t;

  localparam fxp_t FXP_MAX = 16'sh7FFF;
  localparam fxp_t FXP_MIN = 16'sh8000;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } acc_state_e;

endpackage

// File: rtl/fxp_sat_narrow.sv
// Narrows a wide signed accumulator to DATA_WIDTH: clamps when FXP_ACC_SATURATE_EN
// is defined, otherwise keeps the low bits (two's-complement wrap).
module fxp_sat_narrow
  import lenet_fxp_pkg::*;
#(
  parameter int ACC_WIDTH  = 21,
  parameter int DATA_WIDTH = FXP_DATA_WIDTH
) (
  input  logic signed [ACC_WIDTH-1:0]  din,
  output logic signed [DATA_WIDTH-1:0] dout
);

`ifdef FXP_ACC_SATURATE_EN
  logic pos_ovf;
  logic neg_ovf;

  // Value fits only if every bit above the result sign bit matches the accumulator sign.
  always_comb begin
    pos_ovf = !din[ACC_WIDTH-1] && (din[ACC_WIDTH-2:DATA_WIDTH-1] != '0);
    neg_ovf =  din[ACC_WIDTH-1] && (din[ACC_WIDTH-2:DATA_WIDTH-1] != '1);
    if (pos_ovf)
      dout = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (neg_ovf)
      dout = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else
      dout = din[DATA_WIDTH-1:0];
  end
`else
  logic unused_hi;

  assign unused_hi = ^din[ACC_WIDTH-1:DATA_WIDTH];
  assign dout      = din[DATA_WIDTH-1:0];
`endif

endmodule

// File: rtl/fixed_point_acc.sv
// Streaming Q6.10 window accumulator: bias + KERNEL_SIZE products -> one result.
// Output limiting selected by FXP_ACC_SATURATE_EN (see fxp_sat_narrow).
module fixed_point_acc
  import lenet_fxp_pkg::*;
#(
  parameter int DATA_WIDTH  = FXP_DATA_WIDTH,
  parameter int INTEGER     = FXP_INTEGER,
  parameter int FRACTION    = FXP_FRACTION,
  parameter int KERNEL_SIZE = 25
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic signed [DATA_WIDTH-1:0] bias,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         busy
);

  localparam int ACC_WIDTH = DATA_WIDTH + $clog2(KERNEL_SIZE + 1);
  localparam int CNT_WIDTH = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(KERNEL_SIZE - 1);

  generate
    if ((INTEGER + FRACTION != DATA_WIDTH) || (KERNEL_SIZE < 1) || (KERNEL_SIZE > 1024)) begin : g_bad_cfg
      $error("fixed_point_acc: illegal parameter combination");
    end
  endgenerate

  acc_state_e                   state, state_n;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [ACC_WIDTH-1:0]  sum;
  logic signed [DATA_WIDTH-1:0] narrowed;
  logic [CNT_WIDTH-1:0]         cnt;
  logic                         take;
  logic                         first_beat;
  logic                         last_beat;

  always_comb begin
    out_valid  = (state == HOLD);
    in_ready   = !out_valid || out_ready;
    take       = in_valid && in_ready;
    first_beat = (cnt == '0);
    last_beat  = (cnt == LAST_CNT);
    busy       = (cnt != '0);
    sum = (first_beat ? {{(ACC_WIDTH-DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias} : acc)
        + {{(ACC_WIDTH-DATA_WIDTH){in_data[DATA_WIDTH-1]}}, in_data};
  end

  fxp_sat_narrow #(
    .ACC_WIDTH (ACC_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_narrow (
    .din (sum),
    .dout(narrowed)
  );

  // A beat accepted in HOLD also consumes the held result, so HOLD can move
  // straight to ACCUM (or back to HOLD when every beat is a last beat).
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (take) state_n = last_beat ? HOLD : ACCUM;
      ACCUM:   if (take && last_beat) state_n = HOLD;
      HOLD: begin
        if (take)           state_n = last_beat ? HOLD : ACCUM;
        else if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      out_data <= '0;
    end else begin
      state <= state_n;
      if (take) begin
        acc <= sum;
        cnt <= last_beat ? '0 : cnt + 1'b1;
        if (last_beat)
          out_data <= narrowed;
      end
    end
  end

endmodule

// File: tb/tb_fixed_point_acc.sv
// Directed self-checking bench for fixed_point_acc (KERNEL_SIZE 25 and 1 instances).
module tb_fixed_point_acc;
  import lenet_fxp_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic signed [15:0] in_data, bias, out_data;
  logic        in_valid1, in_ready1, out_valid1, out_ready1, busy1;
  logic signed [15:0] in_data1, bias1, out_data1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fixed_point_acc #(
    .DATA_WIDTH(16), .INTEGER(6), .FRACTION(10), .KERNEL_SIZE(25)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .bias(bias), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  fixed_point_acc #(
    .DATA_WIDTH(16), .INTEGER(6), .FRACTION(10), .KERNEL_SIZE(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .bias(bias1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_data(out_data1), .busy(busy1)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drives n beats; bias carries b only on the window's first beat, junk otherwise.
  task automatic drive_beats(input int b, input int d, input int n, input bit has_first);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(d);
      bias     = (has_first && i == 0) ? 16'(b) : 16'sh7FFF;
      @(posedge clk); #1;
    end
  endtask

  task automatic run_window(input string name, input int b, input int d, input int exp);
    drive_beats(b, d, 25, 1'b1);
    in_valid = 1'b0;
    check({name, "_valid"}, int'(out_valid), 1);
    check({name, "_data"}, int'(out_data), exp);
    check({name, "_busy"}, int'(busy), 0);
    @(posedge clk); #1;
    check({name, "_drain"}, int'(out_valid), 0);
  endtask

  typedef struct {
    string name;
    int    b;
    int    d;
    int    exp;
  } vec_t;

  vec_t vecs[6];
  int   k1_data[5];
  int   k1_exp[5];

  initial begin
    vecs[0] = '{"half",     0,      512,   12800};
    vecs[1] = '{"negq",     1024,   -256,  -5376};
    vecs[2] = '{"top",      32767,  0,     32767};
`ifdef FXP_ACC_SATURATE_EN
    vecs[3] = '{"ovf_pos",  0,      2048,  32767};
    vecs[4] = '{"ovf_neg",  -1024,  -2048, -32768};
    vecs[5] = '{"ovf_edge", -32768, -1,    -32768};
`else
    vecs[3] = '{"ovf_pos",  0,      2048,  -14336};
    vecs[4] = '{"ovf_neg",  -1024,  -2048, 13312};
    vecs[5] = '{"ovf_edge", -32768, -1,    32743};
`endif
    k1_data = '{100, 100, 200, -50, 100};
    k1_exp  = '{103, 103, 203, -47, 103};

    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; bias = '0; out_ready = 1'b1;
    in_valid1 = 1'b0; in_data1 = '0; bias1 = '0; out_ready1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data",  int'(out_data), 0);
    check("rst_busy",      int'(busy), 0);
    check("rst_in_ready",  int'(in_ready), 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) run_window(vecs[i].name, vecs[i].b, vecs[i].d, vecs[i].exp);

    // Backpressure: stall 5 cycles, then consume and take a first beat together.
    out_ready = 1'b0;
    drive_beats(0, 512, 25, 1'b1);
    in_data = 16'sd1024; bias = 16'sd0;
    for (int k = 0; k < 5; k++) begin
      check("bp_in_ready",  int'(in_ready), 0);
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_out_data",  int'(out_data), 12800);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    check("bp_consumed", int'(out_valid), 0);
    check("bp_busy", int'(busy), 1);
    drive_beats(0, 1024, 24, 1'b0);
    in_valid = 1'b0;
    check("bp_next_valid", int'(out_valid), 1);
    check("bp_next_data", int'(out_data), 25600);
    @(posedge clk); #1;

    // Asynchronous reset mid-window discards the partial sum.
    drive_beats(100, 512, 10, 1'b1);
    in_valid = 1'b0;
    check("pre_rst_busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_out_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_window("post_rst", 0, 1024, 25600);

    // KERNEL_SIZE == 1: every beat is a complete window.
    check("k1_idle_valid", int'(out_valid1), 0);
    for (int i = 0; i < 5; i++) begin
      in_valid1 = 1'b1; bias1 = 16'sd3; in_data1 = 16'(k1_data[i]);
      @(posedge clk); #1;
      check("k1_valid", int'(out_valid1), 1);
      check("k1_data", int'(out_data1), k1_exp[i]);
      check("k1_in_ready", int'(in_ready1), 1);
      check("k1_busy", int'(busy1), 0);
    end
    in_valid1 = 1'b0;
    @(posedge clk); #1;
    check("k1_drain", int'(out_valid1), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fixed_point_acc.md
# fixed_point_acc

Streaming Q6.10 accumulator that sits directly downstream of `fixed_point_mul` in the convolution and fully-connected datapaths. It consumes one 16-bit product per handshake and sums `KERNEL_SIZE` products plus a bias in a wide internal register. It then presents one rounded-to-format, range-limited Q6.10 result on a valid/ready output. One window produces exactly one result; windows are back-to-back with no idle cycle required.

## Interface
- `DATA_WIDTH`, 16: width of products, bias and result (Q`INTEGER`.`FRACTION`).
- `INTEGER`, 6: integer bits including sign.
- `FRACTION`, 10: fraction bits.
- `KERNEL_SIZE`, 25: products per window; legal range 1..1024.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  product beat valid.
- `in_ready`  out  1  block accepts a beat this cycle.
- `in_data`  in  DATA_WIDTH  signed Q6.10 product from the multiplier.
- `bias`  in  DATA_WIDTH  signed Q6.10 bias; sampled only on the first beat of a window.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `out_data`  out  DATA_WIDTH  signed Q6.10 window sum.
- `busy`  out  1  a window is partially accumulated (count ≠ 0).

## Operation
- Accumulator `acc` is signed, `ACC_WIDTH = DATA_WIDTH + clog2(KERNEL_SIZE+1)` bits. Products and bias are sign-extended into it, so no intermediate overflow is possible.
- Beat counter `cnt` counts 0..`KERNEL_SIZE`-1.
- A beat transfers when `in_valid && in_ready`. `in_ready = !out_valid || out_ready`.
- States:
  - IDLE: `cnt == 0`, no result held.
  - ACCUM: `0 < cnt < KERNEL_SIZE`.
  - HOLD: `out_valid` high.
- First beat (`cnt == 0`): `acc <= sext(bias) + sext(in_data)`.
- Later beats: `acc <= acc + sext(in_data)`.
- Last beat (`cnt == KERNEL_SIZE-1`):
  - `out_data` is registered from the final sum (limited per Configuration).
  - `out_valid` is set and `cnt` returns to 0, giving state HOLD.
  - With `KERNEL_SIZE == 1`, the first beat is also the last beat: IDLE goes to HOLD directly.
- HOLD with `out_ready`: `out_valid` clears unless a new last beat lands in the same cycle.
- HOLD with `out_ready` and `in_valid` in the same cycle: the result is consumed and the beat is accepted as the first beat of the next window, so state becomes ACCUM. No bubble is inserted.
- HOLD without `out_ready`: `in_ready` is low, and `out_data` and `out_valid` stay stable.
- No rounding is applied. Results are truncated at bit 0 because inputs are already Q6.10.

## Timing
- Reset values: `in_ready` = 1 (combinational, since `out_valid` = 0), `out_valid` = 0, `out_data` = 0, `busy` = 0, `acc` = 0, `cnt` = 0.
- Latency: `out_valid` rises on the clock edge after the last beat is accepted.
- Throughput: one beat per cycle sustained. Window period is `KERNEL_SIZE` cycles with `out_ready` held high.
- Reset asserted mid-window or in HOLD: the partial sum and any held result are discarded immediately (asynchronous). The first beat after release starts a fresh window.
- `bias` changes mid-window are ignored.

## Configuration
- `FXP_ACC_SATURATE_EN` defined: the final sum is clamped to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1], i.e. [−32768, 32767] raw (−32.0 to +31.999).
- `FXP_ACC_SATURATE_EN` not defined: `out_data` is the low `DATA_WIDTH` bits of `acc` (two's-complement wrap), matching the multiplier's truncation behaviour.
- The macro does not affect the width of the internal accumulator.

## Structure
- Shared package `lenet_fxp_pkg`:
  - `DATA_WIDTH`/`INTEGER`/`FRACTION` defaults.
  - `FXP_MAX`/`FXP_MIN` constants.
  - Typedef `fxp_t` (signed [15:0]).
  - State enum `acc_state_e` {IDLE, ACCUM, HOLD}.
- One sub-module, `fxp_sat_narrow`: combinational narrowing from `ACC_WIDTH` to `DATA_WIDTH`. It clamps when saturation is enabled and truncates otherwise.

## Test plan
- Reset, then 25 beats of `in_data` = 512 (0.5) with bias = 0 -> one `out_data` = 12800 (12.5).
- Bias = 1024 (1.0), 25 beats of −256 (−0.25) -> `out_data` = −5376 (−5.25).
- 25 beats of 2048 (2.0) -> `out_data` = 32767 with `FXP_ACC_SATURATE_EN` defined; −14336 (51200 wrapped) without it.
- Hold `out_ready` = 0 for 5 cycles after a result while `in_valid` = 1 -> `in_ready` = 0, `out_data` stable. Raising `out_ready` consumes the result and accepts the first beat of the next window in the same cycle.
- Assert `rst_n` low after 10 of 25 beats, then run a full window of 1024 -> `out_data` = 25600, with no contribution from the aborted window.
- `KERNEL_SIZE` = 1, continuous beats of 100 with bias = 3 and `out_ready` = 1 -> one result of 103 per cycle, one cycle after each beat.
